// File: rtl/ucode_store.sv
// ucode_store: 2^ADDR_W x WORD_W microprogram control store with a byte-serial loader and a fetch port.
// Latency: uinst/uinst_valid show mem[addr_rom] READ_LAT cycles (1 or 2) after addr_rom is sampled.
// Backpressure: ld_ready is high for the whole LOAD state and gaps in ld_valid stall the load; the fetch side has none.
// Ports: clk/rst (synchronous, active-high); run/addr_rom -> uinst/uinst_valid (fetch);
//        ld_start/ld_base/ld_len/ld_data/ld_valid -> ld_ready/ld_done/busy (load); par_err (sticky).
// Optional: define UCODE_PARITY_EN to store an even-parity bit per entry and suppress words that fail it.
module ucode_store #(
  parameter int ADDR_W   = 8,
  parameter int WORD_W   = 24,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [ADDR_W-1:0] addr_rom,
  output logic [WORD_W-1:0] uinst,
  output logic              uinst_valid,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W-1:0] ld_len,
  input  logic [7:0]        ld_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              busy,
  output logic              par_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int BYTES = WORD_W / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
`ifdef UCODE_PARITY_EN
  localparam int ENT_W = WORD_W + 1;
`else
  localparam int ENT_W = WORD_W;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FETCH} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   word_cnt;
  logic [ADDR_W:0]   len_q;     // one bit wider so a length of 0 can mean the full depth
  logic [BCW-1:0]    byte_cnt;
  logic [WORD_W-1:0] sh, sh_nxt;
  logic [ENT_W-1:0]  mem [DEPTH];
  logic [ENT_W-1:0]  wr_ent, rd_ent, pre_ent;
  logic              pre_vld, par_ok;
  logic              byte_xfer, byte_last, load_last, start_acc, fetch_go, wr_en;

  // Load side: bytes arrive LSB first, so shift in from the top; after BYTES
  // shifts byte 0 sits in bits [7:0].
  assign byte_xfer = (state_q == S_LOAD) & ld_valid;
  assign byte_last = byte_xfer & (byte_cnt == BCW'(BYTES - 1));
  assign load_last = byte_last & ((word_cnt + 1'b1) == len_q);
  assign sh_nxt    = (sh >> 8) | (WORD_W'(ld_data) << (WORD_W - 8));
  assign start_acc = ld_start & (state_q != S_LOAD);
  assign fetch_go  = (state_q == S_FETCH) & run & ~ld_start;
  assign wr_en     = byte_last & ~rst;   // a reset on the final byte must not commit the word

`ifdef UCODE_PARITY_EN
  assign wr_ent = {^sh_nxt, sh_nxt};
`else
  assign wr_ent = sh_nxt;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; ld_start wins over run
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ld_start) state_d = S_LOAD;
               else if (run) state_d = S_FETCH;
      S_LOAD:  if (load_last) state_d = S_IDLE;
      S_FETCH: if (ld_start) state_d = S_LOAD;
               else if (!run) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    ld_ready = 1'b0;
    busy     = 1'b0;
    if (state_q == S_LOAD) begin
      ld_ready = 1'b1;
      busy     = 1'b1;
    end
  end

  // Loader counters and byte assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      word_cnt <= '0;
      len_q    <= '0;
      byte_cnt <= '0;
      sh       <= '0;
      ld_done  <= 1'b0;
    end else begin
      ld_done <= load_last;
      if (start_acc) begin
        wr_ptr   <= ld_base;
        len_q    <= {(ld_len == '0), ld_len};
        word_cnt <= '0;
        byte_cnt <= '0;
      end else if (byte_xfer) begin
        sh <= sh_nxt;
        if (byte_last) begin
          byte_cnt <= '0;
          wr_ptr   <= wr_ptr + 1'b1;
          word_cnt <= word_cnt + 1'b1;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
    end
  end

  // Storage array, not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_ent;
  end

  assign rd_ent = mem[addr_rom];

  // Optional extra read stage; every stage is flushed when fetch stops so
  // in-flight reads never reach the core.
  generate
    if (READ_LAT == 2) begin : g_lat2
      logic             p_vld;
      logic [ENT_W-1:0] p_ent;
      always_ff @(posedge clk) begin
        if (rst || !fetch_go) begin
          p_vld <= 1'b0;
          p_ent <= '0;
        end else begin
          p_vld <= 1'b1;
          p_ent <= rd_ent;
        end
      end
      assign pre_vld = p_vld;
      assign pre_ent = p_ent;
    end else begin : g_lat1
      assign pre_vld = 1'b1;
      assign pre_ent = rd_ent;
    end
  endgenerate

`ifdef UCODE_PARITY_EN
  assign par_ok = ~(^pre_ent);   // data plus stored even-parity bit must XOR to 0

  always_ff @(posedge clk) begin
    if (rst || start_acc)                  par_err <= 1'b0;
    else if (fetch_go && pre_vld && !par_ok) par_err <= 1'b1;
  end
`else
  assign par_ok  = 1'b1;
  assign par_err = 1'b0;
`endif

  // Output stage: the core sees zeros whenever the word is not valid
  always_ff @(posedge clk) begin
    if (rst || !fetch_go || !pre_vld || !par_ok) begin
      uinst       <= '0;
      uinst_valid <= 1'b0;
    end else begin
      uinst       <= pre_ent[WORD_W-1:0];
      uinst_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ucode_store.sv
module tb_ucode_store;
  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst, run, ld_start, ld_valid;
  logic [7:0]  addr_rom, ld_base, ld_len, ld_data;
  logic [23:0] uinst;
  logic        uinst_valid, ld_ready, ld_done, busy, par_err;

  ucode_store #(.ADDR_W(8), .WORD_W(24), .READ_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .run(run), .addr_rom(addr_rom),
    .uinst(uinst), .uinst_valid(uinst_valid),
    .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
    .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_done(ld_done), .busy(busy), .par_err(par_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int exp_done = 0;

  logic [23:0] ref_mem [256];   // reference image of the control store
  logic [23:0] wbuf [256];      // words for the next load
  logic [7:0]  faddr [64];      // addresses for the next fetch run

  always @(negedge clk) if (ld_done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Loads wbuf[0..n-1] starting at base; with gaps, idle cycles (carrying
  // junk ld_start pulses that must be ignored) are inserted before bytes.
  task automatic do_load(input logic [7:0] base, input logic [7:0] len, input bit gaps);
    int n;
    int glitch;
    bit last;
    n = (len == 8'd0) ? 256 : int'(len);
    glitch = 0;
    ld_start = 1'b1; ld_base = base; ld_len = len;
    step;
    ld_start = 1'b0;
    chk("ld_ready_on_entry", 32'(ld_ready), 1);
    chk("busy_on_entry", 32'(busy), 1);
    chk("vld_in_load", 32'(uinst_valid), 0);
    chk("uinst_in_load", 32'(uinst), 0);
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < 3; b++) begin
        if (gaps) begin
          repeat ($urandom_range(0, 2)) begin
            ld_valid = 1'b0;
            ld_start = 1'($urandom_range(0, 1));
            ld_base = 8'($urandom); ld_len = 8'($urandom);
            step;
            if (ld_done !== 1'b0 || ld_ready !== 1'b1) glitch++;
            ld_start = 1'b0;
          end
        end
        ld_valid = 1'b1;
        ld_data = wbuf[w][8*b +: 8];
        step;
        last = (w == n - 1) && (b == 2);
        if (!last && (ld_done !== 1'b0 || ld_ready !== 1'b1)) glitch++;
      end
    end
    ld_valid = 1'b0;
    chk("ld_done_pulse", 32'(ld_done), 1);
    chk("ld_ready_drop", 32'(ld_ready), 0);
    chk("busy_drop", 32'(busy), 0);
    chk("load_glitches", 32'(glitch), 0);
    for (int w = 0; w < n; w++) ref_mem[8'(int'(base) + w)] = wbuf[w];
    exp_done++;
    step;
    chk("ld_done_one_cycle", 32'(ld_done), 0);
  endtask

  // Fetches faddr[0..n-1] starting from IDLE; tail extra cycles drain the
  // pipe before run drops (tail < LAT-1 stops mid-stream).
  task automatic do_fetch(input int n, input int tail);
    int k;
    run = 1'b1;
    addr_rom = faddr[0];
    step;
    chk("warmup_vld", 32'(uinst_valid), 0);
    chk("warmup_uinst", 32'(uinst), 0);
    for (int j = 0; j < n + tail; j++) begin
      addr_rom = faddr[(j < n) ? j : n - 1];
      step;
      k = j - (LAT - 1);
      if (k >= 0 && k < n) begin
        chk("fetch_vld", 32'(uinst_valid), 1);
        chk("fetch_uinst", 32'(uinst), 32'(ref_mem[faddr[k]]));
      end else begin
        chk("fetch_warm_vld", 32'(uinst_valid), 0);
        chk("fetch_warm_uinst", 32'(uinst), 0);
      end
    end
    run = 1'b0;
    step;
    chk("stop_vld", 32'(uinst_valid), 0);
    chk("stop_uinst", 32'(uinst), 0);
    step;
    chk("idle_vld", 32'(uinst_valid), 0);
  endtask

  initial begin
    logic [7:0] base, len;
    rst = 1'b1; run = 1'b0; ld_start = 1'b0; ld_valid = 1'b0;
    addr_rom = 8'h0; ld_base = 8'h0; ld_len = 8'h0; ld_data = 8'h0;
    step; step;
    chk("rst_uinst", 32'(uinst), 0);
    chk("rst_vld", 32'(uinst_valid), 0);
    chk("rst_ld_ready", 32'(ld_ready), 0);
    chk("rst_ld_done", 32'(ld_done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_par_err", 32'(par_err), 0);
    rst = 1'b0;
    step;

    // Directed load then fetch
    wbuf[0] = 24'h332211; wbuf[1] = 24'h665544;
    do_load(8'h10, 8'd2, 1'b0);
    faddr[0] = 8'h10; faddr[1] = 8'h11;
    do_fetch(2, LAT - 1);

    // Full-depth load wrapping from 0xFF
    for (int i = 0; i < 256; i++) wbuf[i] = 24'($urandom);
    do_load(8'hFF, 8'd0, 1'b0);
    faddr[0] = 8'hFF; faddr[1] = 8'h00; faddr[2] = 8'hFE; faddr[3] = 8'h7F;
    do_fetch(4, LAT - 1);

    // Random loads with gapped ld_valid, then fetch inside the loaded window
    for (int r = 0; r < 4; r++) begin
      base = 8'($urandom);
      len = 8'($urandom_range(1, 20));
      for (int i = 0; i < int'(len); i++) wbuf[i] = 24'($urandom);
      do_load(base, len, 1'b1);
      for (int i = 0; i < 12; i++) faddr[i] = 8'(int'(base) + $urandom_range(0, int'(len) - 1));
      do_fetch(12, LAT - 1);
    end

    // run dropped mid-stream, then restarted with warm-up
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) faddr[i] = 8'($urandom);
      do_fetch(10, 0);
    end

    // Abort an active fetch with a new load
    run = 1'b1;
    addr_rom = 8'h33;
    step;
    repeat (LAT) step;
    chk("pre_abort_vld", 32'(uinst_valid), 1);
    chk("pre_abort_uinst", 32'(uinst), 32'(ref_mem[8'h33]));
    for (int i = 0; i < 3; i++) wbuf[i] = 24'($urandom);
    do_load(8'h50, 8'd3, 1'b0);
    run = 1'b0;
    step; step;
    for (int i = 0; i < 3; i++) faddr[i] = 8'(8'h50 + i);
    do_fetch(3, LAT - 1);

    // Reset mid-load, with the reset cycle carrying the word's last byte
    ld_start = 1'b1; ld_base = 8'h20; ld_len = 8'd1;
    step;
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 8'hAA; step;
    ld_data = 8'hBB; step;
    ld_data = 8'hCC; rst = 1'b1; step;
    rst = 1'b0; ld_valid = 1'b0;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ld_ready", 32'(ld_ready), 0);
    chk("midrst_ld_done", 32'(ld_done), 0);
    chk("midrst_vld", 32'(uinst_valid), 0);
    chk("midrst_uinst", 32'(uinst), 0);
    chk("midrst_par_err", 32'(par_err), 0);
    step; step;
    chk("done_count", 32'(done_cnt), 32'(exp_done));
    faddr[0] = 8'h20; faddr[1] = 8'h21;
    do_fetch(2, LAT - 1);

`ifdef UCODE_PARITY_EN
    dut.mem[8'h40][5] = ~dut.mem[8'h40][5];
    run = 1'b1;
    addr_rom = 8'h40;
    step;
    repeat (LAT) step;
    chk("par_bad_vld", 32'(uinst_valid), 0);
    chk("par_bad_uinst", 32'(uinst), 0);
    chk("par_err_set", 32'(par_err), 1);
    addr_rom = 8'h41;
    repeat (LAT) step;
    chk("par_good_vld", 32'(uinst_valid), 1);
    chk("par_good_uinst", 32'(uinst), 32'(ref_mem[8'h41]));
    run = 1'b0;
    step; step;
    chk("par_err_sticky", 32'(par_err), 1);
    wbuf[0] = 24'($urandom);
    do_load(8'h40, 8'd1, 1'b0);
    chk("par_err_cleared", 32'(par_err), 0);
`endif

    chk("done_count_end", 32'(done_cnt), 32'(exp_done));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
